pipe_scroller: RTL and testbench

Game-state producer for the pipe obstacles, upstream of game_render_controller. It owns the X/Y positions of the three pipe pairs and scrolls them left at a fixed divided rate. Each pipe that leaves the left edge respawns off the right edge with a pseudo-random gap height. It emits a one-cycle update strobe that drives the renderer's pipe write enables, and a score pulse when a pipe passes the bird column.

---
 rtl/flappy_pkg.sv | 18 +
 rtl/pipe_scroller_lfsr16.sv | 19 +
 rtl/pipe_scroller.sv | 141 ++++++++++++++
 tb/tb_pipe_scroller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Geometry and coordinate types shared by the game producers and game_render_controller,
// so collision, scoring and render geometry all agree.
package flappy_pkg;

    localparam int COORD_W  = 17;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int PIPE_W   = 52;
    localparam int BIRD_X   = 160;

    typedef logic signed [COORD_W-1:0] coord_t;

    // Widen a plain integer constant into the signed coordinate domain.
    function automatic coord_t to_coord(input int v);
        return coord_t'(v);
    endfunction

endpackage

// File: rtl/pipe_scroller_lfsr16.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1); a nonzero seed keeps it off zero.
module lfsr16 (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    localparam logic [15:0] TAPS = 16'hB400;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            q <= seed;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/pipe_scroller.sv
// Scrolls three pipe pairs left at a divided rate, respawning each off the right edge
// with an LFSR-chosen gap height; emits an update strobe and a score pulse.
module pipe_scroller
    import flappy_pkg::COORD_W;
    import flappy_pkg::coord_t;
    import flappy_pkg::to_coord;
#(
    parameter int          SPEED_DIVIDER  = 500000,
    parameter int          STEP           = 1,
    parameter int          SCREEN_W       = flappy_pkg::SCREEN_W,
    parameter int          PIPE_W         = flappy_pkg::PIPE_W,
    parameter int          PIPE_SPACING   = 240,
    parameter int          GAP_MIN_Y      = 40,
    parameter int          GAP_RANGE_LOG2 = 8,
    parameter int          BIRD_X         = flappy_pkg::BIRD_X,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      iRun,
    input  logic                      iRestart,
    output logic signed [COORD_W-1:0] oPipe1X,
    output logic signed [COORD_W-1:0] oPipe2X,
    output logic signed [COORD_W-1:0] oPipe3X,
    output logic signed [COORD_W-1:0] oPipe1Y,
    output logic signed [COORD_W-1:0] oPipe2Y,
    output logic signed [COORD_W-1:0] oPipe3Y,
    output logic                      oUpdate,
    output logic                      oScore
);

    localparam int                 CNT_W      = $clog2(SPEED_DIVIDER);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(SPEED_DIVIDER - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam int                 NUM_PIPES  = 3;

    localparam coord_t STEP_C     = to_coord(STEP);
    localparam coord_t NEG_PIPE_W = to_coord(-PIPE_W);
    localparam coord_t RESPAWN_DX = to_coord(NUM_PIPES * PIPE_SPACING);
    localparam coord_t PIPE_W_C   = to_coord(PIPE_W);
    localparam coord_t BIRD_X_C   = to_coord(BIRD_X);
    localparam coord_t Y_INIT     = to_coord(GAP_MIN_Y + (1 << (GAP_RANGE_LOG2 - 1)));

    function automatic coord_t init_x(input int k);
        return to_coord(SCREEN_W + k * PIPE_SPACING);
    endfunction

    // Gap top drawn from the low LFSR bits, zero-extended so it never goes below GAP_MIN_Y.
    function automatic coord_t respawn_y(input logic [15:0] r);
        return to_coord(GAP_MIN_Y) + coord_t'(r[GAP_RANGE_LOG2-1:0]);
    endfunction

    logic [15:0]      lfsr_q;
    logic [CNT_W-1:0] cnt_p0;
    logic             tick_p0;
    coord_t           xn_p0    [NUM_PIPES];
    coord_t           x_d_p0   [NUM_PIPES];
    coord_t           y_d_p0   [NUM_PIPES];
    logic             cross_p0 [NUM_PIPES];
    logic             any_cross_p0;

    coord_t           x_p1     [NUM_PIPES];
    coord_t           y_p1     [NUM_PIPES];
    logic             vld_p1;
    logic             score_p1;

    lfsr16 u_lfsr (
        .clock  (clock),
        .resetn (resetn),
        .seed   (LFSR_SEED),
        .q      (lfsr_q)
    );

    // Stage p0: divider tick and next-position arithmetic for every pipe.
    assign tick_p0 = iRun && (cnt_p0 == CNT_LAST);

    always_comb begin
        any_cross_p0 = 1'b0;
        for (int k = 0; k < NUM_PIPES; k++) begin
            xn_p0[k]    = x_p1[k] - STEP_C;
            cross_p0[k] = ((x_p1[k] + PIPE_W_C) >= BIRD_X_C) &&
                          ((xn_p0[k] + PIPE_W_C) < BIRD_X_C);
            if (xn_p0[k] < NEG_PIPE_W) begin
                x_d_p0[k] = xn_p0[k] + RESPAWN_DX;
                y_d_p0[k] = respawn_y(lfsr_q);
            end else begin
                x_d_p0[k] = xn_p0[k];
                y_d_p0[k] = y_p1[k];
            end
            any_cross_p0 = any_cross_p0 | cross_p0[k];
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_p0 <= '0;
        end else if (iRestart) begin
            cnt_p0 <= '0;
        end else if (iRun) begin
            cnt_p0 <= tick_p0 ? '0 : cnt_p0 + CNT_ONE;
        end
    end

    // Stage p1: registered positions and strobes, visible the cycle after the tick.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int k = 0; k < NUM_PIPES; k++) begin
                x_p1[k] <= init_x(k);
                y_p1[k] <= Y_INIT;
            end
            vld_p1   <= 1'b0;
            score_p1 <= 1'b0;
        end else if (iRestart) begin
            for (int k = 0; k < NUM_PIPES; k++) begin
                x_p1[k] <= init_x(k);
                y_p1[k] <= Y_INIT;
            end
            vld_p1   <= 1'b1;
            score_p1 <= 1'b0;
        end else begin
            vld_p1   <= tick_p0;
            score_p1 <= tick_p0 && any_cross_p0;
            if (tick_p0) begin
                for (int k = 0; k < NUM_PIPES; k++) begin
                    x_p1[k] <= x_d_p0[k];
                    y_p1[k] <= y_d_p0[k];
                end
            end
        end
    end

    assign oPipe1X = x_p1[0];
    assign oPipe2X = x_p1[1];
    assign oPipe3X = x_p1[2];
    assign oPipe1Y = y_p1[0];
    assign oPipe2Y = y_p1[1];
    assign oPipe3Y = y_p1[2];
    assign oUpdate = vld_p1;
    assign oScore  = score_p1;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller with a fast divider; expected values are hand-derived,
// respawn heights come from an independent LFSR reference.
module tb_pipe_scroller;

    localparam int DIV = 4;

    logic               clock = 1'b0;
    logic               resetn;
    logic               iRun;
    logic               iRestart;
    logic signed [16:0] oPipe1X, oPipe2X, oPipe3X;
    logic signed [16:0] oPipe1Y, oPipe2Y, oPipe3Y;
    logic               oUpdate;
    logic               oScore;

    int                 n_checks = 0;
    int                 n_pass   = 0;

    logic [15:0]        m_lfsr;
    logic [15:0]        lfsr_prev;
    longint             y_wrap_a, y_wrap_b;

    pipe_scroller #(.SPEED_DIVIDER(DIV)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .iRun     (iRun),
        .iRestart (iRestart),
        .oPipe1X  (oPipe1X),
        .oPipe2X  (oPipe2X),
        .oPipe3X  (oPipe3X),
        .oPipe1Y  (oPipe1Y),
        .oPipe2Y  (oPipe2Y),
        .oPipe3Y  (oPipe3Y),
        .oUpdate  (oUpdate),
        .oScore   (oScore)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] gal_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSR, reset and advanced exactly like the pipe height source.
    always @(posedge clock) begin
        if (!resetn) m_lfsr <= 16'hACE1;
        else         m_lfsr <= gal_next(m_lfsr);
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic step();
        lfsr_prev = m_lfsr;
        @(posedge clock);
        #1;
    endtask

    task automatic tick_wait();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!oUpdate && n < 2 * DIV + 2);
        if (!oUpdate) check("tick_timeout", 0, 1);
    endtask

    task automatic run_until_x1(input longint target);
        int guard;
        guard = 0;
        while (oPipe1X != target && guard < 1000) begin
            tick_wait();
            guard++;
        end
        check("reach_x1", oPipe1X, target);
    endtask

    task automatic check_reset_pos(input string tag);
        check({tag, "_x1"}, oPipe1X, 640);
        check({tag, "_x2"}, oPipe2X, 880);
        check({tag, "_x3"}, oPipe3X, 1120);
        check({tag, "_y1"}, oPipe1Y, 168);
        check({tag, "_y2"}, oPipe2Y, 168);
        check({tag, "_y3"}, oPipe3Y, 168);
    endtask

    initial begin
        resetn = 1'b0; iRun = 1'b0; iRestart = 1'b0;
        step();
        check_reset_pos("rst");
        check("rst_upd", oUpdate, 0);
        check("rst_score", oScore, 0);

        // Scroll rate: update on every fourth edge with X1 stepping by one.
        resetn = 1'b1; iRun = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("rate_upd", oUpdate, (i % 4 == 0) ? 1 : 0);
            if (i % 4 == 0) check("rate_x1", oPipe1X, 640 - i / 4);
        end
        check("rate_x2", oPipe2X, 877);

        // Pause keeps the divider phase.
        step(); step();
        iRun = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("pause_upd", oUpdate, 0);
        end
        iRun = 1'b1;
        step();
        check("resume_upd1", oUpdate, 0);
        step();
        check("resume_upd2", oUpdate, 1);
        check("resume_x1", oPipe1X, 636);

        // Run falling in the tick cycle suppresses the tick and holds the counter.
        step(); step(); step();
        iRun = 1'b0;
        step();
        check("supp_upd", oUpdate, 0);
        step();
        check("supp_hold", oUpdate, 0);
        iRun = 1'b1;
        step();
        check("supp_resume_upd", oUpdate, 1);
        check("supp_resume_x1", oPipe1X, 635);

        // Score: X1 from 109->108 does not score, 108->107 does.
        run_until_x1(108);
        check("score_108", oScore, 0);
        tick_wait();
        check("score_x1", oPipe1X, 107);
        check("score_pulse", oScore, 1);
        step();
        check("score_between", oScore, 0);
        tick_wait();
        check("score_next", oScore, 0);

        // Wrap of pipe 1.
        run_until_x1(-52);
        tick_wait();
        check("wrap_x1", oPipe1X, 667);
        check("wrap_y1", oPipe1Y, 40 + longint'(lfsr_prev[7:0]));
        check("wrap_y1_range", (oPipe1Y >= 40 && oPipe1Y <= 295) ? 1 : 0, 1);
        check("wrap_x2", oPipe2X, 187);
        check("wrap_x3", oPipe3X, 427);
        check("wrap_y2", oPipe2Y, 168);

        // Restart alone, then force a wrap.
        iRestart = 1'b1;
        step();
        iRestart = 1'b0;
        check_reset_pos("rs1");
        check("rs1_upd", oUpdate, 1);
        step();
        check("rs1_upd_off", oUpdate, 0);
        run_until_x1(-52);
        tick_wait();
        y_wrap_a = 40 + longint'(lfsr_prev[7:0]);
        check("rs1_wrap_x1", oPipe1X, 667);
        check("rs1_wrap_y1", oPipe1Y, y_wrap_a);

        iRun = 1'b0;
        for (int i = 0; i < 37; i++) step();
        iRun = 1'b1;
        iRestart = 1'b1;
        step();
        iRestart = 1'b0;
        check_reset_pos("rs2");
        run_until_x1(-52);
        tick_wait();
        y_wrap_b = 40 + longint'(lfsr_prev[7:0]);
        check("rs2_wrap_x1", oPipe1X, 667);
        check("rs2_wrap_y1", oPipe1Y, y_wrap_b);
        check("rs_y_differ", (oPipe1Y != y_wrap_a) ? 1 : 0, (y_wrap_b != y_wrap_a) ? 1 : 0);

        // Reset together with restart: reset wins, LFSR reseeded, no update strobe.
        resetn = 1'b0; iRestart = 1'b1;
        step();
        check_reset_pos("rr");
        check("rr_upd", oUpdate, 0);
        check("rr_score", oScore, 0);
        check("rr_lfsr", dut.u_lfsr.q, 16'hACE1);
        resetn = 1'b1; iRestart = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1);
    end

endmodule
